// File: rtl/ibf_issue_ctrl.sv
// Ingress scheduler for the inverse-butterfly extractor: buffers {mode,data} beats,
// issues mode MODE_LEAD cycles ahead of data and meters in-flight beats with credits.
module ibf_issue_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MODE_WIDTH = 2,
  parameter int NUM_MODES  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int MODE_LEAD  = 2,
  parameter int CREDITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [MODE_WIDTH-1:0] s_mode,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  flush,
  input  logic                  cred_ret,
  output logic [MODE_WIDTH-1:0] mode_o,
  output logic                  dval_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  err_mode,
  output logic                  err_cred,
  output logic [7:0]            drop_cnt,
  output logic [7:0]            credit_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int EW  = MODE_WIDTH + DATA_WIDTH;
  localparam int DIW = PW + 1;
  localparam logic [7:0] CRED_INIT = 8'(CREDITS);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_reg, state_next;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_sync_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_reg[1];

  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg, occ;
  logic                  fifo_empty, fifo_full;
  logic [EW-1:0]         rd_entry;
  logic [MODE_WIDTH-1:0] mode_reg;
  logic [MODE_LEAD-1:0]  pipe_vld_reg;
  logic [DATA_WIDTH-1:0] pipe_data_reg [MODE_LEAD];
  logic                  dval_reg, err_mode_reg, err_cred_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [7:0]            credit_reg, credit_next, drop_cnt_reg, drop_next;
  logic                  accept, mode_legal, flush_take, fifo_wr, issue, cred_over;
  logic [DIW-1:0]        drop_inc;
  logic [15:0]           drop_sum;

  assign occ        = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                      (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign rd_entry   = fifo_mem[rd_ptr_reg[AW-1:0]];

  assign s_ready    = rst_sync_n && (state_reg != FLUSH) && !fifo_full;
  assign accept     = s_valid && s_ready;
  assign mode_legal = (32'(s_mode) < 32'(NUM_MODES));
  assign flush_take = flush && (state_reg != FLUSH);
  // A legal beat handshaken on the flush edge is discarded along with the buffer.
  assign fifo_wr    = accept && mode_legal && !flush_take;
  assign issue      = (state_reg == RUN) && !fifo_empty && (credit_reg != 8'd0) && !flush_take;
  assign cred_over  = cred_ret && !issue && (credit_reg == CRED_INIT);

  assign drop_inc = (flush_take ? (DIW'(occ) + DIW'(accept && mode_legal)) : '0) +
                    DIW'(accept && !mode_legal);
  assign drop_sum  = {8'd0, drop_cnt_reg} + 16'(drop_inc);
  assign drop_next = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];

  always_comb begin
    credit_next = credit_reg;
    if (issue && !cred_ret)                  credit_next = credit_reg - 8'd1;
    else if (cred_ret && !issue && !cred_over) credit_next = credit_reg + 8'd1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (flush_take) state_next = FLUSH;
               else if (!fifo_empty || fifo_wr) state_next = RUN;
      RUN:     if (flush_take) state_next = FLUSH;
               else if (fifo_empty && !fifo_wr) state_next = IDLE;
      FLUSH:   if (pipe_vld_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_reg[AW-1:0]] <= {s_mode, s_data};
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      mode_reg     <= '0;
      pipe_vld_reg <= '0;
      for (int i = 0; i < MODE_LEAD; i++) pipe_data_reg[i] <= '0;
      dval_reg     <= 1'b0;
      data_reg     <= '0;
      err_mode_reg <= 1'b0;
      err_cred_reg <= 1'b0;
      credit_reg   <= CRED_INIT;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (flush_take) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (issue)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (issue) begin
        mode_reg         <= rd_entry[EW-1 -: MODE_WIDTH];
        pipe_data_reg[0] <= rd_entry[DATA_WIDTH-1:0];
      end
      // Beats already in the delay line keep moving through a flush.
      pipe_vld_reg[0] <= issue;
      for (int i = 1; i < MODE_LEAD; i++) begin
        pipe_vld_reg[i]  <= pipe_vld_reg[i-1];
        pipe_data_reg[i] <= pipe_data_reg[i-1];
      end
      dval_reg <= pipe_vld_reg[MODE_LEAD-1];
      if (pipe_vld_reg[MODE_LEAD-1]) data_reg <= pipe_data_reg[MODE_LEAD-1];
      err_mode_reg <= accept && !mode_legal;
      err_cred_reg <= cred_over;
      credit_reg   <= credit_next;
      drop_cnt_reg <= drop_next;
    end
  end

  assign mode_o   = mode_reg;
  assign dval_o   = dval_reg;
  assign data_o   = data_reg;
  assign err_mode = err_mode_reg;
  assign err_cred = err_cred_reg;
  assign drop_cnt = drop_cnt_reg;
  assign credit_o = credit_reg;
endmodule

// File: tb/tb_ibf_issue_ctrl.sv
// Scoreboard bench for ibf_issue_ctrl: legal beats are queued when sent and
// matched against dval_o/data_o, with mode_o checked two cycles ahead of data.
module tb_ibf_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  s_mode = '0;
  logic [15:0] s_data = '0;
  logic        flush = 1'b0;
  logic        cred_ret = 1'b0;
  logic [1:0]  mode_o;
  logic        dval_o;
  logic [15:0] data_o;
  logic        err_mode, err_cred;
  logic [7:0]  drop_cnt, credit_o;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_checks = 0;
  int    n_pass = 0;
  int    dval_cnt = 0;
  int    errm_cnt = 0;
  logic [1:0] mh1 = '0, mh2 = '0;

  ibf_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_mode(s_mode), .s_data(s_data), .flush(flush), .cred_ret(cred_ret),
    .mode_o(mode_o), .dval_o(dval_o), .data_o(data_o), .err_mode(err_mode),
    .err_cred(err_cred), .drop_cnt(drop_cnt), .credit_o(credit_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Output monitor: every dval_o must match the oldest queued beat.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (dval_o) begin
        dval_cnt++;
        check("dval_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_b = exp_q.pop_front();
          check("data_o", 32'(data_o), 32'(mon_b.data));
          check("mode_lead", 32'(mh2), 32'(mon_b.mode));
          $display("beat out: mode=%0d data=0x%04h", mh2, data_o);
        end
      end
      if (err_mode) errm_cnt++;
      mh2 = mh1;
      mh1 = mode_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(s_ready), 1);
  endtask

  task automatic send(input logic [1:0] m, input logic [15:0] d);
    int    n = 0;
    beat_t b;
    s_valid = 1'b1;
    s_mode  = m;
    s_data  = d;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    check("hs_wait", 32'(n < 100), 1);
    b.mode = m;
    b.data = d;
    if (m < 2'd3) exp_q.push_back(b);
    $display("beat in: mode=%0d data=0x%04h", m, d);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic cret(input int n);
    cred_ret = 1'b1;
    tick_n(n);
    cred_ret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int e0;

    tick_n(3);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_credit", 32'(credit_o), 8);
    check("rst_dval", 32'(dval_o), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    wait_ready();

    // single beat latency
    send(2'd1, 16'hA5A5);
    tick();
    check("t1_mode", 32'(mode_o), 1);
    check("t1_dval_early", 32'(dval_o), 0);
    check("t1_credit", 32'(credit_o), 7);
    tick();
    check("t1_dval_lead1", 32'(dval_o), 0);
    tick();
    check("t1_dval", 32'(dval_o), 1);
    check("t1_data", 32'(data_o), 32'hA5A5);
    tick();
    check("t1_dval_once", 32'(dval_o), 0);
    check("t1_data_hold", 32'(data_o), 32'hA5A5);
    cret(1);
    check("t1_credit_back", 32'(credit_o), 8);

    // credit exhaustion fills the FIFO
    base = dval_cnt;
    for (int i = 0; i < 12; i++) send(2'(i % 3), 16'h1000 + 16'(i));
    tick_n(6);
    check("t2_issued8", 32'(dval_cnt - base), 8);
    check("t2_credit0", 32'(credit_o), 0);
    check("t2_full_ready", 32'(s_ready), 0);
    cret(3);
    tick_n(6);
    check("t2_issued11", 32'(dval_cnt - base), 11);
    check("t2_credit0b", 32'(credit_o), 0);
    check("t2_ready_back", 32'(s_ready), 1);
    cret(1);
    tick_n(5);
    check("t2_issued12", 32'(dval_cnt - base), 12);
    cret(8);
    check("t2_credit8", 32'(credit_o), 8);

    // illegal mode between legal beats
    e0 = errm_cnt;
    send(2'd0, 16'h2222);
    send(2'd3, 16'h3333);
    check("t3_err_pulse", 32'(err_mode), 1);
    send(2'd2, 16'h4444);
    check("t3_err_clear", 32'(err_mode), 0);
    tick_n(5);
    check("t3_err_count", 32'(errm_cnt - e0), 1);
    check("t3_drop", 32'(drop_cnt), 1);
    check("t3_credit", 32'(credit_o), 6);
    cret(2);

    // flush a full FIFO while out of credit
    for (int i = 0; i < 12; i++) send(2'(i % 3), 16'h5000 + 16'(i));
    tick_n(5);
    check("t4_credit0", 32'(credit_o), 0);
    check("t4_ready0", 32'(s_ready), 0);
    check("t4_pending", 32'(exp_q.size()), 4);
    repeat (4) void'(exp_q.pop_back());
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_flush_ready", 32'(s_ready), 0);
    check("t4_drop", 32'(drop_cnt), 5);
    tick();
    check("t4_idle_ready", 32'(s_ready), 1);
    tick_n(4);
    cret(8);
    check("t4_credit8", 32'(credit_o), 8);

    // flush one cycle after an issue: the in-flight beat still emerges
    send(2'd2, 16'hBEEF);
    tick();
    check("t5_mode", 32'(mode_o), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_ready_flush", 32'(s_ready), 0);
    check("t5_dval_early", 32'(dval_o), 0);
    tick();
    check("t5_dval", 32'(dval_o), 1);
    check("t5_data", 32'(data_o), 32'hBEEF);
    check("t5_still_flush", 32'(s_ready), 0);
    tick();
    check("t5_exit", 32'(s_ready), 1);
    check("t5_drop", 32'(drop_cnt), 5);
    check("t5_credit", 32'(credit_o), 7);

    // credit overflow and simultaneous issue/return
    cret(1);
    check("t6_credit8", 32'(credit_o), 8);
    check("t6_no_err", 32'(err_cred), 0);
    cret(1);
    check("t6_ovf_credit", 32'(credit_o), 8);
    check("t6_err_cred", 32'(err_cred), 1);
    tick();
    check("t6_err_clear", 32'(err_cred), 0);
    send(2'd0, 16'h6666);
    cred_ret = 1'b1;
    tick();
    cred_ret = 1'b0;
    check("t6_both_credit", 32'(credit_o), 8);
    check("t6_both_err", 32'(err_cred), 0);
    tick_n(4);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) send(2'd2, 16'h7000 + 16'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_mode", 32'(mode_o), 0);
    check("t7_dval", 32'(dval_o), 0);
    check("t7_data", 32'(data_o), 0);
    check("t7_credit", 32'(credit_o), 8);
    check("t7_drop", 32'(drop_cnt), 0);
    check("t7_ready", 32'(s_ready), 0);
    exp_q.delete();
    tick_n(2);
    rst_n = 1'b1;
    wait_ready();
    send(2'd1, 16'h8888);
    tick_n(5);
    check("final_credit", 32'(credit_o), 7);
    check("final_q_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
